// File: rtl/dht_start_ctrl.sv
// dht_start_ctrl
// ----------------------------------------------------------------------------
// Start-pulse generator and response checker for DHT11/DHT22 single-wire
// sensors. The host pulls the line low for a mode-dependent time. It then
// releases the line and checks the sensor's low/high response pair. A valid
// response produces a one-cycle confirm pulse for the bit receiver.
//
// Handshake: a transaction is accepted when start=1 while the block is idle
// (busy=0). busy stays high until the cycle the FSM is back in IDLE. start
// seen while busy is dropped; there is no queuing.
//
// Optional build macro: DHT_START_RETRY_EN
//   When defined, a failed handshake is retried up to two more times. Each
//   retry first holds the line released for LOW_CYC_DHT22 cycles (GUARD).
//
// Ports:
//   clk                 system clock
//   rst                 synchronous active-low reset
//   start               transaction request, sampled only in IDLE
//   mode                0 = DHT11, 1 = DHT22; latched on accepted start
//   dq_in               raw (asynchronous) line level from the pad
//   dq_oe               1 = pull line low, 0 = release
//   busy                high from accepted start until back in IDLE
//   out_delay           one-cycle pulse when the host low phase ends
//   confirm_to_reciver  one-cycle pulse when the response is validated
//   err                 sticky error flag, cleared on next accepted start
//   err_code            00 none, 01 no response, 10 low phase bad,
//                       11 high phase bad
//   dbg_state           current FSM state encoding, for checkers/debug
// ----------------------------------------------------------------------------
module dht_start_ctrl #(
    parameter int LOW_CYC_DHT11 = 18000,
    parameter int LOW_CYC_DHT22 = 1100,
    parameter int REL_MAX       = 60,
    parameter int RESP_MIN      = 60,
    parameter int RESP_MAX      = 100,
    parameter int CNT_W         = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       mode,
    input  logic       dq_in,
    output logic       dq_oe,
    output logic       busy,
    output logic       out_delay,
    output logic       confirm_to_reciver,
    output logic       err,
    output logic [1:0] err_code,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DRIVE_LOW = 3'd1,
        S_RELEASE   = 3'd2,
        S_RESP_LOW  = 3'd3,
        S_RESP_HIGH = 3'd4,
        S_ERR       = 3'd5
`ifdef DHT_START_RETRY_EN
        , S_GUARD   = 3'd6
`endif
    } state_t;

    localparam logic [CNT_W-1:0] C_LOW11_LAST = CNT_W'(LOW_CYC_DHT11 - 1);
    localparam logic [CNT_W-1:0] C_LOW22_LAST = CNT_W'(LOW_CYC_DHT22 - 1);
    localparam logic [CNT_W-1:0] C_REL_MAX    = CNT_W'(REL_MAX);
    localparam logic [CNT_W-1:0] C_RESP_MIN   = CNT_W'(RESP_MIN);
    localparam logic [CNT_W-1:0] C_RESP_MAX   = CNT_W'(RESP_MAX);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_mode;
    logic             r_dq_m;
    logic             r_dq_s;
    logic [1:0]       r_code;
`ifdef DHT_START_RETRY_EN
    logic [1:0]       r_retry;
`endif

    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_low_last;
    logic             w_in_window;

    // Counter saturates at all-ones instead of wrapping.
    assign w_cnt_inc   = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;
    assign w_low_last  = r_mode ? C_LOW22_LAST : C_LOW11_LAST;
    assign w_in_window = (r_cnt >= C_RESP_MIN) && (r_cnt <= C_RESP_MAX);
    assign dbg_state   = r_state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state            <= S_IDLE;
            r_cnt              <= '0;
            r_mode             <= 1'b0;
            r_dq_m             <= 1'b1;
            r_dq_s             <= 1'b1;
            r_code             <= 2'b00;
            dq_oe              <= 1'b0;
            busy               <= 1'b0;
            out_delay          <= 1'b0;
            confirm_to_reciver <= 1'b0;
            err                <= 1'b0;
            err_code           <= 2'b00;
`ifdef DHT_START_RETRY_EN
            r_retry            <= 2'd0;
`endif
        end else begin
            r_dq_m             <= dq_in;
            r_dq_s             <= r_dq_m;
            out_delay          <= 1'b0;
            confirm_to_reciver <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode   <= mode;
                        err      <= 1'b0;
                        err_code <= 2'b00;
                        r_cnt    <= '0;
                        dq_oe    <= 1'b1;
                        busy     <= 1'b1;
                        r_state  <= S_DRIVE_LOW;
`ifdef DHT_START_RETRY_EN
                        r_retry  <= 2'd0;
`endif
                    end
                end

                // dq_oe was raised on entry, so it is high for exactly
                // w_low_last+1 cycles.
                S_DRIVE_LOW: begin
                    if (r_cnt == w_low_last) begin
                        out_delay <= 1'b1;
                        r_cnt     <= '0;
                        dq_oe     <= 1'b0;
                        r_state   <= S_RELEASE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end

                S_RELEASE: begin
                    if (!r_dq_s) begin
                        r_cnt   <= '0;
                        r_state <= S_RESP_LOW;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc >= C_REL_MAX) begin
                            r_code  <= 2'b01;
                            r_state <= S_ERR;
                        end
                    end
                end

                // A phase that is still running past RESP_MAX fails at once
                // rather than waiting for the edge.
                S_RESP_LOW: begin
                    if (r_dq_s) begin
                        if (w_in_window) begin
                            r_cnt   <= '0;
                            r_state <= S_RESP_HIGH;
                        end else begin
                            r_code  <= 2'b10;
                            r_state <= S_ERR;
                        end
                    end else if (w_cnt_inc > C_RESP_MAX) begin
                        r_code  <= 2'b10;
                        r_state <= S_ERR;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end

                S_RESP_HIGH: begin
                    if (!r_dq_s) begin
                        if (w_in_window) begin
                            confirm_to_reciver <= 1'b1;
                            busy               <= 1'b0;
                            r_cnt              <= '0;
                            r_state            <= S_IDLE;
                        end else begin
                            r_code  <= 2'b11;
                            r_state <= S_ERR;
                        end
                    end else if (w_cnt_inc > C_RESP_MAX) begin
                        r_code  <= 2'b11;
                        r_state <= S_ERR;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end

                S_ERR: begin
`ifdef DHT_START_RETRY_EN
                    if (r_retry < 2'd2) begin
                        r_retry <= r_retry + 2'd1;
                        r_cnt   <= '0;
                        r_state <= S_GUARD;
                    end else
`endif
                    begin
                        err      <= 1'b1;
                        err_code <= r_code;
                        busy     <= 1'b0;
                        r_cnt    <= '0;
                        r_state  <= S_IDLE;
                    end
                end

`ifdef DHT_START_RETRY_EN
                // Line stays released so the sensor can recover before the
                // next start pulse.
                S_GUARD: begin
                    if (r_cnt == C_LOW22_LAST) begin
                        r_cnt   <= '0;
                        dq_oe   <= 1'b1;
                        r_state <= S_DRIVE_LOW;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
`endif

                default: begin
                    dq_oe   <= 1'b0;
                    busy    <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dht_start_ctrl.sv
// tb_dht_start_ctrl
// ----------------------------------------------------------------------------
// Self-checking bench for dht_start_ctrl with small timing parameters.
// A table of handshake scenarios goes through a behavioural sensor model.
// Hand-written sequences then cover reset, release timeout latency,
// mid-transaction reset and a start held high.
// ----------------------------------------------------------------------------
module tb_dht_start_ctrl;

    localparam int LOW11 = 20;
    localparam int LOW22 = 5;
    localparam int RELM  = 8;
    localparam int RMIN  = 4;
    localparam int RMAX  = 12;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       mode;
    logic       dq_in;
    logic       dq_oe;
    logic       busy;
    logic       out_delay;
    logic       confirm;
    logic       err;
    logic [1:0] err_code;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    dht_start_ctrl #(
        .LOW_CYC_DHT11 (LOW11),
        .LOW_CYC_DHT22 (LOW22),
        .REL_MAX       (RELM),
        .RESP_MIN      (RMIN),
        .RESP_MAX      (RMAX),
        .CNT_W         (15)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .mode               (mode),
        .dq_in              (dq_in),
        .dq_oe              (dq_oe),
        .busy               (busy),
        .out_delay          (out_delay),
        .confirm_to_reciver (confirm),
        .err                (err),
        .err_code           (err_code),
        .dbg_state          (dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;

    int         oe_len;
    int         pulses;
    int         od_cnt;
    int         cf_cnt;
    int         overlap;
    int         rel2idle;
    int         timed_out;
    logic       res_err;
    logic [1:0] res_code;
    logic       busy_after;

    typedef struct {
        logic       m;
        bit         tog;
        int         rel;
        int         lo;
        int         hi;
        int         exp_len;
        int         exp_cf;
        logic       exp_err;
        logic [1:0] exp_code;
    } vec_t;

    vec_t vecs[12];

    // Inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    // Sensor line level, t = cycles since the host released the line
    // (t<0 while the host drives or before the first release).
    function automatic logic sensor(input int t, input int rel, input int lo,
                                    input int hi);
        if (t < 0)             return 1'b1;
        if (t < rel)           return 1'b1;
        if (t < rel + lo)      return 1'b0;
        if (t < rel + lo + hi) return 1'b1;
        return 1'b0;
    endfunction

    // ---------------- driver ----------------
    task automatic run_txn(input logic m, input bit tog, input int rel,
                           input int lo, input int hi);
        int t;
        int cur;
        int first_rel;
        bit prev_oe;
        bit seen;
        bit done;
        oe_len = 0; pulses = 0; od_cnt = 0; cf_cnt = 0; overlap = 0;
        rel2idle = 0; timed_out = 0;
        t = -1; cur = 0; first_rel = -1; prev_oe = 1'b0; seen = 1'b0;
        done = 1'b0;
        mode  = m;
        start = 1'b1;
        dq_in = 1'b1;
        step();
        start = 1'b0;
        for (int n = 0; n < 3000 && !done; n++) begin
            if (dq_oe && !prev_oe) begin
                pulses++;
                cur = 0;
            end
            if (dq_oe) begin
                cur++;
                t = -1;
            end
            if (!dq_oe && prev_oe) begin
                if (pulses == 1) oe_len = cur;
                if (first_rel < 0) first_rel = n;
                t = 0;
            end
            if (out_delay) od_cnt++;
            if (confirm) cf_cnt++;
            if (out_delay && confirm) overlap++;
            if (busy) seen = 1'b1;
            if (seen && !busy) begin
                done     = 1'b1;
                rel2idle = n - first_rel;
                start    = 1'b0;
            end else begin
                if (tog) begin
                    mode  = ~mode;
                    start = ~start;
                end
                dq_in = sensor(t, rel, lo, hi);
                if (t >= 0) t++;
                prev_oe = dq_oe;
                step();
            end
        end
        if (!done) timed_out = 1;
        res_err  = err;
        res_code = err_code;
        step();
        if (confirm) cf_cnt++;
        busy_after = busy;
    endtask

    // ---------------- stimulus + checks ----------------
    initial begin
        int exp_pulses;
        int n;
        // {mode, toggle, rel, low, high, oe_len, confirms, err, code}
        vecs[0]  = '{1'b0, 1'b0,    3,  8,  8, LOW11, 1, 1'b0, 2'b00};
        vecs[1]  = '{1'b1, 1'b1,    3,  8,  8, LOW22, 1, 1'b0, 2'b00};
        vecs[2]  = '{1'b0, 1'b0, 1000,  8,  8, LOW11, 0, 1'b1, 2'b01};
        vecs[3]  = '{1'b1, 1'b0,    3,  2,  8, LOW22, 0, 1'b1, 2'b10};
        vecs[4]  = '{1'b1, 1'b0,    3,  8, 15, LOW22, 0, 1'b1, 2'b11};
        vecs[5]  = '{1'b1, 1'b0,    5,  5,  5, LOW22, 1, 1'b0, 2'b00};
        vecs[6]  = '{1'b1, 1'b0,    6,  8,  8, LOW22, 0, 1'b1, 2'b01};
        vecs[7]  = '{1'b1, 1'b0,    0,  4,  8, LOW22, 0, 1'b1, 2'b10};
        vecs[8]  = '{1'b1, 1'b0,    2, 13, 13, LOW22, 1, 1'b0, 2'b00};
        vecs[9]  = '{1'b1, 1'b0,    2, 14,  8, LOW22, 0, 1'b1, 2'b10};
        vecs[10] = '{1'b1, 1'b0,    2,  8, 14, LOW22, 0, 1'b1, 2'b11};
        vecs[11] = '{1'b1, 1'b0,    2,  8,  4, LOW22, 0, 1'b1, 2'b11};

        // Reset / idle
        rst = 1'b0; start = 1'b0; mode = 1'b0; dq_in = 1'b1;
        repeat (3) step();
        chk("rst_dq_oe", dq_oe, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("idle%0d_dq_oe", i), dq_oe, 0);
            chk($sformatf("idle%0d_busy", i), busy, 0);
            chk($sformatf("idle%0d_pulses", i), {30'd0, out_delay, confirm}, 0);
            chk($sformatf("idle%0d_err", i), {29'd0, err, err_code}, 0);
        end

        // Table-driven handshakes
        for (int i = 0; i < 12; i++) begin
`ifdef DHT_START_RETRY_EN
            exp_pulses = vecs[i].exp_err ? 3 : 1;
`else
            exp_pulses = 1;
`endif
            run_txn(vecs[i].m, vecs[i].tog, vecs[i].rel, vecs[i].lo, vecs[i].hi);
            chk($sformatf("v%0d_timeout", i), timed_out, 0);
            chk($sformatf("v%0d_oe_len", i), oe_len, vecs[i].exp_len);
            chk($sformatf("v%0d_drive_pulses", i), pulses, exp_pulses);
            chk($sformatf("v%0d_out_delay", i), od_cnt, exp_pulses);
            chk($sformatf("v%0d_confirm", i), cf_cnt, vecs[i].exp_cf);
            chk($sformatf("v%0d_overlap", i), overlap, 0);
            chk($sformatf("v%0d_err", i), res_err, vecs[i].exp_err);
            chk($sformatf("v%0d_err_code", i), res_code, vecs[i].exp_code);
            chk($sformatf("v%0d_busy_after", i), busy_after, 0);
        end

        // Release timeout: cycles from first release to busy low.
        // Each retry adds RELEASE 8 + ERR 1 + GUARD 5 + DRIVE 5 = 19 cycles.
        run_txn(1'b1, 1'b0, 1000, 8, 8);
`ifdef DHT_START_RETRY_EN
        chk("norsp_rel2idle", rel2idle, RELM + 1 + 2 * (RELM + 1 + LOW22 + LOW22));
`else
        chk("norsp_rel2idle", rel2idle, RELM + 1);
`endif
        chk("norsp_code", res_code, 1);

        // Reset in the middle of DRIVE_LOW
        mode = 1'b0; start = 1'b1; dq_in = 1'b1;
        step();
        start = 1'b0;
        repeat (9) step();
        chk("mid_dq_oe_before", dq_oe, 1);
        rst = 1'b0;
        step();
        chk("mid_rst_dq_oe", dq_oe, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_pulses", {30'd0, out_delay, confirm}, 0);
        chk("mid_rst_err", err, 0);
        rst = 1'b1;
        step();
        chk("mid_post_busy", busy, 0);
        run_txn(1'b0, 1'b0, 3, 8, 8);
        chk("mid_again_oe_len", oe_len, LOW11);
        chk("mid_again_confirm", cf_cnt, 1);
        chk("mid_again_err", res_err, 0);

        // start held high across IDLE re-arms immediately; err clears
        mode = 1'b1; start = 1'b1; dq_in = 1'b1;
        step();
        chk("held_busy", busy, 1);
        n = 0;
        while (busy && n < 500) begin step(); n++; end
        chk("held_timeout1", n < 500 ? 0 : 1, 0);
        chk("held_err1", {29'd0, err, err_code}, 5);
        step();
        chk("held_rearm_busy", busy, 1);
        chk("held_err_cleared", {29'd0, err, err_code}, 0);
        start = 1'b0;
        n = 0;
        while (busy && n < 500) begin step(); n++; end
        chk("held_timeout2", n < 500 ? 0 : 1, 0);
        chk("held_err2", err, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
